dct_pp_ctrl: RTL and testbench
==============================

Name: dct_pp_ctrl

Overview:
- Sequencer for one 8x8 DCT row stage: loads an 8-sample row of X, issues 64 MAC operations (8 coefficients x 8 samples), and writes the 8 resulting partial products into the 8-entry partial-product register bank via wa/enreg.
- Hands the completed bank (qr0..qr7) downstream with a valid/ready handshake.
- Repeats for ROWS rows per block.
- Sits between the input row buffer / coefficient ROM / MAC and the partial-product register bank.

Parameters:
- MAC_LAT, 2, cycles from MAC operand issue (mac_en) to accumulator result valid at the bank's din.
- ROWS, 8, rows per block.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a block; sampled only in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts a sample (LOAD state).
- x_we  out  1  write strobe to the 8-entry input row buffer.
- x_addr  out  3  row buffer address (write in LOAD, read in CALC).
- c_addr  out  6  coefficient ROM address {k,j}.
- mac_en  out  1  MAC operand issue.
- mac_clr  out  1  accumulator clear-and-load (first term, j==0).
- enreg  out  1  bank write enable.
- wa  out  3  bank write address (k).
- out_valid  out  1  qr0..qr7 hold a complete row.
- out_ready  in  1  downstream consumes the row.
- row_idx  out  3  current row number.
- busy  out  1  state != IDLE.
- block_done  out  1  one-cycle pulse after the last row's FLUSH.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all counters 0; all outputs 0, including out_valid and the tag pipeline.
  - Reset mid-operation abandons the row; no enreg is issued afterwards.
- States: IDLE, LOAD, HOLD, CALC, FLUSH.
- IDLE:
  - start=1 -> LOAD, with row_idx=0.
- LOAD:
  - in_ready=1.
  - On each in_valid: x_we=1 and x_addr=scnt; scnt increments.
  - After the 8th accepted sample: -> CALC if out_valid=0, else -> HOLD.
- HOLD:
  - in_ready=0; waits until out_valid=0, then -> CALC.
  - This guarantees qr is never overwritten before it is consumed.
- CALC: exactly 64 cycles; 6-bit counter {k,j}, j inner.
  - mac_en=1, x_addr=j, c_addr={k,j}, mac_clr=(j==0).
  - A MAC_LAT-deep shift register carries a tag (valid=(j==7), k).
  - When a tag emerges: enreg=1 and wa=k. The enreg for coefficient k therefore occurs at CALC cycle 8k+7+MAC_LAT.
  - After the count reaches 63: -> FLUSH.
- FLUSH: exactly MAC_LAT cycles.
  - mac_en=0; the remaining tags drain, including wa=7.
  - At exit:
    - If row_idx==ROWS-1: block_done=1 for one cycle, row_idx=0, -> IDLE.
    - Otherwise: row_idx increments, -> LOAD.
- enreg is asserted only from the tag pipeline. Sequence per row: wa=0..7, each a single-cycle pulse, spaced 8 cycles apart.
- out_valid:
  - Set on the clock edge where enreg=1 and wa=7 (same edge the bank updates qr).
  - Cleared on out_valid & out_ready.
  - If set and clear coincide, set wins (unreachable under the HOLD guard, but required).
- start while busy: ignored.
- in_valid outside LOAD: ignored (in_ready=0).
- out_ready while out_valid=0: no effect.
- Throughput with out_ready held at 1: 8 + 64 + MAC_LAT cycles per row.

Decomposition:
- Shared package dct_pkg:
  - State enum (IDLE, LOAD, HOLD, CALC, FLUSH).
  - N=8 and the address widths (3-bit sample/bank address, 6-bit coefficient address).
- Sub-module dct_tag_pipe: parameterised MAC_LAT-deep shift register of {valid, k[2:0]}, with asynchronous reset to 0.

Test Plan:
- Reset, then start=1 with 8 back-to-back in_valid: in_ready high for 8 cycles; x_addr 0..7; CALC begins; with MAC_LAT=2, enreg pulses at CALC cycles 9, 17, ..., 65 with wa 0..7; out_valid rises after wa=7.
- in_valid gapped (every other cycle): LOAD lasts 15 cycles; x_addr order and count unchanged; CALC starts only after the 8th sample.
- out_ready=0 at the end of row 0 while row 1 is loaded: controller enters HOLD with no mac_en and no enreg; raising out_ready gives one handshake, then CALC starts the next cycle.
- Full block, ROWS=8, out_ready=1: row_idx goes 0..7; 64 enreg pulses in total; block_done pulses exactly once; then IDLE with busy=0.
- Assert rst_n=0 mid-CALC (e.g. k=3): all outputs 0 immediately; after release the block stays in IDLE with no residual enreg from the tag pipeline.
- MAC_LAT=4 build: FLUSH lasts 4 cycles; first enreg at CALC cycle 11; mac_clr asserted only on j==0 cycles.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and sizes for the DCT row-stage sequencer.
package dct_pkg;

  localparam int unsigned N         = 8;
  localparam int unsigned AddrW     = 3;  // sample / bank address
  localparam int unsigned CoefAddrW = 6;  // coefficient ROM address {k,j}

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHold,
    StCalc,
    StFlush
  } state_e;

  // Tag that travels alongside a MAC operation: valid marks the last term (j==7) of row k.
  typedef struct packed {
    logic             valid;
    logic [AddrW-1:0] k;
  } tag_t;

endpackage

// File: rtl/dct_tag_pipe.sv
// Depth-stage shift register that delays MAC tags to line up with accumulator results.
module dct_tag_pipe
  import dct_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [Depth-1:0] pipe_q;

  // Shift tags one stage per cycle; reset flushes any in-flight writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i < Depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_out = pipe_q[Depth-1];

endmodule

// File: rtl/dct_pp_ctrl.sv
// Row-stage sequencer: load 8 samples, issue 64 MACs, write 8 partial products, hand off.
module dct_pp_ctrl
  import dct_pkg::*;
#(
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned ROWS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 x_we,
  output logic [AddrW-1:0]     x_addr,
  output logic [CoefAddrW-1:0] c_addr,
  output logic                 mac_en,
  output logic                 mac_clr,
  output logic                 enreg,
  output logic [AddrW-1:0]     wa,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AddrW-1:0]     row_idx,
  output logic                 busy,
  output logic                 block_done
);

  localparam logic [AddrW-1:0]     SampLast  = AddrW'(N - 1);
  localparam logic [AddrW-1:0]     RowLast   = AddrW'(ROWS - 1);
  localparam logic [CoefAddrW-1:0] FlushLast = CoefAddrW'(MAC_LAT - 1);

  state_e                 state_q, state_d;
  logic [AddrW-1:0]       scnt_q, scnt_d;
  logic [AddrW-1:0]       row_q, row_d;
  logic [CoefAddrW-1:0]   ccnt_q, ccnt_d;  // {k,j} in CALC, cycle count in FLUSH
  logic                   out_valid_q, out_valid_d;
  logic                   block_done_q, block_done_d;
  logic [AddrW-1:0]       k, j;
  tag_t                   tag_in, tag_out;

  assign k = ccnt_q[5:3];
  assign j = ccnt_q[2:0];

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      scnt_q       <= '0;
      row_q        <= '0;
      ccnt_q       <= '0;
      out_valid_q  <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      row_q        <= row_d;
      ccnt_q       <= ccnt_d;
      out_valid_q  <= out_valid_d;
      block_done_q <= block_done_d;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    row_d        = row_q;
    ccnt_d       = ccnt_q;
    block_done_d = 1'b0;
    in_ready     = 1'b0;
    x_we         = 1'b0;
    x_addr       = '0;
    c_addr       = '0;
    mac_en       = 1'b0;
    mac_clr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          row_d   = '0;
          scnt_d  = '0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        x_addr   = scnt_q;
        if (in_valid) begin
          x_we   = 1'b1;
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == SampLast) begin
            ccnt_d  = '0;
            state_d = out_valid_q ? StHold : StCalc;
          end
        end
      end
      StHold: begin
        // Leave as soon as the pending row is consumed on this edge.
        if (!out_valid_q || out_ready) begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        mac_en  = 1'b1;
        x_addr  = j;
        c_addr  = ccnt_q;
        mac_clr = (j == '0);
        ccnt_d  = ccnt_q + 1'b1;  // wraps to 0 for the FLUSH count
        if (ccnt_q == '1) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        ccnt_d = ccnt_q + 1'b1;
        if (ccnt_q == FlushLast) begin
          ccnt_d = '0;
          scnt_d = '0;
          if (row_q == RowLast) begin
            block_done_d = 1'b1;
            row_d        = '0;
            state_d      = StIdle;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tag enters with the operand; it emerges when the accumulator result reaches the bank.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state_q == StCalc) && (j == SampLast);
    tag_in.k     = k;
  end

  dct_tag_pipe #(
    .Depth (MAC_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign enreg = tag_out.valid;
  assign wa    = tag_out.valid ? tag_out.k : '0;

  // Output handshake: set on the final bank write, set wins over a coincident clear.
  always_comb begin
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (tag_out.valid && (tag_out.k == SampLast)) begin
      out_valid_d = 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign row_idx    = row_q;
  assign busy       = (state_q != StIdle);
  assign block_done = block_done_q;

endmodule

// File: tb/tb_dct_pp_ctrl.sv
// Directed bench for dct_pp_ctrl (MAC_LAT=2 main instance, MAC_LAT=4 second instance).
module tb_dct_pp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, x_we, mac_en, mac_clr, enreg, out_valid, busy, block_done;
  logic [2:0] x_addr, wa, row_idx;
  logic [5:0] c_addr;

  logic       start4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b1;
  logic       in_ready4, x_we4, mac_en4, mac_clr4, enreg4, out_valid4, busy4, block_done4;
  logic [2:0] x_addr4, wa4, row_idx4;
  logic [5:0] c_addr4;

  int n_tests = 0;
  int n_fail  = 0;
  int n_en    = 0;

  always #5 clk = ~clk;

  dct_pp_ctrl #(.MAC_LAT(2), .ROWS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x_we(x_we), .x_addr(x_addr), .c_addr(c_addr), .mac_en(mac_en), .mac_clr(mac_clr),
    .enreg(enreg), .wa(wa), .out_valid(out_valid), .out_ready(out_ready),
    .row_idx(row_idx), .busy(busy), .block_done(block_done)
  );

  dct_pp_ctrl #(.MAC_LAT(4), .ROWS(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
    .x_we(x_we4), .x_addr(x_addr4), .c_addr(c_addr4), .mac_en(mac_en4), .mac_clr(mac_clr4),
    .enreg(enreg4), .wa(wa4), .out_valid(out_valid4), .out_ready(out_ready4),
    .row_idx(row_idx4), .busy(busy4), .block_done(block_done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed 8 samples, back-to-back or on every other cycle.
  task automatic load_row(input bit gapped, input int row);
    int s = 0;
    int cyc = 0;
    while (s < 8) begin
      in_valid = !gapped || (cyc % 2 == 0);
      #1;
      check("load_in_ready", in_ready, 1);
      check("load_row_idx", row_idx, row);
      check("load_x_we", x_we, in_valid);
      check("load_mac_en", mac_en, 0);
      if (in_valid) begin
        check("load_x_addr", x_addr, s);
        s++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    check("load_exit_in_ready", in_ready, 0);
  endtask

  // Walk 64 CALC cycles plus 2 FLUSH cycles; noise drives start/in_valid which must be ignored.
  task automatic run_calc(input bit noise);
    for (int c = 0; c < 66; c++) begin
      bit exp_en;
      start    = noise && (c < 60);
      in_valid = noise && (c < 60);
      #1;
      exp_en = (c >= 9) && ((c - 9) % 8 == 0);
      check("calc_mac_en", mac_en, (c < 64));
      if (c < 64) begin
        check("calc_c_addr", c_addr, c);
        check("calc_x_addr", x_addr, c % 8);
        check("calc_mac_clr", mac_clr, (c % 8 == 0));
      end
      check("calc_enreg", enreg, exp_en);
      if (exp_en) check("calc_wa", wa, (c - 9) / 8);
      check("calc_x_we", x_we, 0);
      check("calc_in_ready", in_ready, 0);
      check("calc_out_valid", out_valid, 0);
      n_en += int'(enreg);
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("row_out_valid_set", out_valid, 1);
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_enreg", enreg, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_block_done", block_done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Row 0: back-to-back load.
    out_ready = 1'b1;
    start = 1'b1;
    #1;
    check("idle_busy", busy, 0);
    tick();
    start = 1'b0;
    load_row(0, 0);
    run_calc(0);
    check("row0_block_done", block_done, 0);
    check("row0_next_row", row_idx, 1);

    // Row 1: gapped load; hold the result so row 2 lands in HOLD.
    load_row(1, 1);
    out_ready = 1'b0;
    run_calc(0);

    // Row 2: loaded while row 1 is still pending.
    load_row(0, 2);
    for (int i = 0; i < 3; i++) begin
      check("hold_in_ready", in_ready, 0);
      check("hold_mac_en", mac_en, 0);
      check("hold_enreg", enreg, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("hold_handshake_valid", out_valid, 1);
    tick();
    check("hold_cleared", out_valid, 0);
    run_calc(0);

    // Rows 3..7, with ignored start/in_valid noise during row 3.
    for (int r = 3; r < 8; r++) begin
      load_row(0, r);
      run_calc(r == 3);
      check("row_block_done", block_done, (r == 7));
    end
    check("blk_busy", busy, 0);
    check("blk_row_idx", row_idx, 0);
    check("blk_enreg_total", n_en, 64);
    tick();
    check("blk_done_pulse_end", block_done, 0);
    check("blk_out_valid_clr", out_valid, 0);

    // Reset in the middle of CALC at k=3.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_row(0, 0);
    for (int c = 0; c < 26; c++) tick();
    check("midrst_c_addr", c_addr, 26);
    rst_n = 1'b0;
    #1;
    check("midrst_mac_en", mac_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_c_addr0", c_addr, 0);
    check("midrst_enreg", enreg, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("postrst_enreg", enreg, 0);
      check("postrst_busy", busy, 0);
      tick();
    end

    // MAC_LAT=4 instance: first write at CALC cycle 11, 4-cycle FLUSH.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    in_valid4 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    in_valid4 = 1'b0;
    for (int c = 0; c < 68; c++) begin
      bit exp_en;
      #1;
      exp_en = (c >= 11) && ((c - 11) % 8 == 0);
      check("l4_mac_en", mac_en4, (c < 64));
      check("l4_mac_clr", mac_clr4, (c < 64) && (c % 8 == 0));
      check("l4_enreg", enreg4, exp_en);
      if (exp_en) check("l4_wa", wa4, (c - 11) / 8);
      check("l4_in_ready", in_ready4, 0);
      tick();
    end
    check("l4_next_load", in_ready4, 1);
    check("l4_row_idx", row_idx4, 1);
    check("l4_out_valid", out_valid4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
